// File: rtl/serial_mag_compare.sv
// Word-level magnitude resolver fed by a 1-bit comparator slice, MSB first.
// It consumes one-hot gt/eq/lt flags per beat and produces a held word result.
// Once the deciding bit is seen, it drops slice_en while the rest of the word drains.
module serial_mag_compare #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_gt,
    input  logic             in_eq,
    input  logic             in_lt,
    output logic             slice_en,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             res_gt,
    output logic             res_eq,
    output logic             res_lt,
    output logic             res_err,
    output logic [CNT_W-1:0] res_pos
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SKIP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_s;
    logic               gt_s;
    logic               eq_s;
    logic               lt_s;
    logic               err_s;
    logic [CNT_W-1:0]   pos_s;
    logic               beat_s;
    logic               last_s;

    // Next-state, beat counter and next result fields for the word in flight.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        gt_s    = res_gt;
        eq_s    = res_eq;
        lt_s    = res_lt;
        err_s   = res_err;
        pos_s   = res_pos;
        beat_s  = in_valid && in_ready;
        last_s  = (count_r == LAST_POS);

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SCAN;
                    count_s = '0;
                    gt_s    = 1'b0;
                    eq_s    = 1'b0;
                    lt_s    = 1'b0;
                    err_s   = 1'b0;
                    pos_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (beat_s) begin
                    case ({in_gt, in_eq, in_lt})
                        3'b100, 3'b001: begin
                            gt_s    = in_gt;
                            eq_s    = 1'b0;
                            lt_s    = in_lt;
                            err_s   = 1'b0;
                            pos_s   = count_r;
                            state_s = last_s ? DONE : SKIP;
                        end
                        3'b010: begin
                            if (last_s) begin
                                eq_s    = 1'b1;
                                pos_s   = LAST_POS;
                                state_s = DONE;
                            end else begin
                                state_s = SCAN;
                            end
                        end
                        default: begin
                            // Zero, two or three flags high: the slice is misbehaving.
                            gt_s    = 1'b0;
                            eq_s    = 1'b0;
                            lt_s    = 1'b0;
                            err_s   = 1'b1;
                            pos_s   = count_r;
                            state_s = last_s ? DONE : SKIP;
                        end
                    endcase
                    if (!last_s) begin
                        count_s = count_r + 1'b1;
                    end else begin
                        count_s = count_r;
                    end
                end else begin
                    state_s = SCAN;
                end
            end
            SKIP: begin
                // Flags are ignored here; only the beat count matters.
                if (beat_s) begin
                    if (last_s) begin
                        state_s = DONE;
                    end else begin
                        count_s = count_r + 1'b1;
                    end
                end else begin
                    state_s = SKIP;
                end
            end
            DONE: begin
                if (res_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter and all outputs registered; status outputs decode the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            count_r   <= '0;
            in_ready  <= 1'b0;
            slice_en  <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_gt    <= 1'b0;
            res_eq    <= 1'b0;
            res_lt    <= 1'b0;
            res_err   <= 1'b0;
            res_pos   <= '0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            in_ready  <= (state_s == SCAN) || (state_s == SKIP);
            slice_en  <= (state_s == SCAN);
            busy      <= (state_s == SCAN) || (state_s == SKIP);
            res_valid <= (state_s == DONE);
            res_gt    <= gt_s;
            res_eq    <= eq_s;
            res_lt    <= lt_s;
            res_err   <= err_s;
            res_pos   <= pos_s;
        end
    end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed, table-driven bench for serial_mag_compare (WIDTH=8).
module tb_serial_mag_compare;

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;
    localparam logic [2:0] F_NO = 3'b000;
    localparam logic [2:0] F_GL = 3'b101;
    localparam logic [2:0] F_AL = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_gt = 1'b0;
    logic       in_eq = 1'b0;
    logic       in_lt = 1'b0;
    logic       slice_en;
    logic       busy;
    logic       res_valid;
    logic       res_ack = 1'b0;
    logic       res_gt;
    logic       res_eq;
    logic       res_lt;
    logic       res_err;
    logic [3:0] res_pos;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [23:0] flags;     // beat i at flags[23-3*i -: 3], {gt,eq,lt}
        int          stall_at;  // beat index preceded by 5 idle cycles, -1 none
        logic [3:0]  exp_res;   // {gt,eq,lt,err}
        logic [3:0]  exp_pos;
    } vec_t;

    vec_t vecs [10];

    serial_mag_compare #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_gt(in_gt), .in_eq(in_eq), .in_lt(in_lt),
        .slice_en(slice_en), .busy(busy), .res_valid(res_valid),
        .res_ack(res_ack), .res_gt(res_gt), .res_eq(res_eq), .res_lt(res_lt),
        .res_err(res_err), .res_pos(res_pos)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [23:0] fl, int st, logic [3:0] r, logic [3:0] p);
        vec_t v;
        v.flags    = fl;
        v.stall_at = st;
        v.exp_res  = r;
        v.exp_pos  = p;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [3:0] r, input logic [3:0] p);
        chk({tag, " res_gt"},  32'(res_gt),  32'(r[3]));
        chk({tag, " res_eq"},  32'(res_eq),  32'(r[2]));
        chk({tag, " res_lt"},  32'(res_lt),  32'(r[1]));
        chk({tag, " res_err"}, 32'(res_err), 32'(r[0]));
        chk({tag, " res_pos"}, 32'(res_pos), 32'(p));
    endtask

    // Runs one word; hold keeps DONE for 10 cycles with start pulses before acking.
    task automatic run_word(input vec_t v, input bit hold);
        logic [2:0] f;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy after start", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == v.stall_at) begin
                in_valid = 1'b0;
                {in_gt, in_eq, in_lt} = F_AL;
                for (int k = 0; k < 5; k++) begin
                    chk("stall in_ready", 32'(in_ready), 32'd1);
                    chk("stall slice_en", 32'(slice_en), 32'(i <= int'(v.exp_pos)));
                    chk("stall res_valid", 32'(res_valid), 32'd0);
                    step();
                end
            end
            f = v.flags[23 - 3*i -: 3];
            in_valid = 1'b1;
            {in_gt, in_eq, in_lt} = f;
            chk("beat in_ready", 32'(in_ready), 32'd1);
            chk("beat busy", 32'(busy), 32'd1);
            chk("beat slice_en", 32'(slice_en), 32'(i <= int'(v.exp_pos)));
            chk("beat res_valid", 32'(res_valid), 32'd0);
            step();
        end
        in_valid = 1'b0;
        {in_gt, in_eq, in_lt} = F_NO;
        chk("done res_valid", 32'(res_valid), 32'd1);
        chk("done in_ready", 32'(in_ready), 32'd0);
        chk("done busy", 32'(busy), 32'd0);
        chk("done slice_en", 32'(slice_en), 32'd0);
        chk_result("done", v.exp_res, v.exp_pos);
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                start = (k % 2 == 0);
                step();
                chk("hold res_valid", 32'(res_valid), 32'd1);
                chk("hold busy", 32'(busy), 32'd0);
                chk_result("hold", v.exp_res, v.exp_pos);
            end
            start = 1'b1;
        end
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        start = 1'b0;
        chk("ack res_valid", 32'(res_valid), 32'd0);
        chk("ack busy", 32'(busy), 32'd0);
        chk("ack in_ready", 32'(in_ready), 32'd0);
        chk_result("retained", v.exp_res, v.exp_pos);
        if (hold) begin
            step();
            chk("start with ack ignored", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = mk({F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ}, -1, 4'b0100, 4'd7);
        vecs[1] = mk({F_EQ, F_EQ, F_EQ, F_GT, F_EQ, F_EQ, F_EQ, F_EQ}, -1, 4'b1000, 4'd3);
        vecs[2] = mk({F_LT, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ},  4, 4'b0010, 4'd0);
        vecs[3] = mk({F_EQ, F_EQ, F_GL, F_NO, F_AL, F_GT, F_LT, F_GL}, -1, 4'b0001, 4'd2);
        vecs[4] = mk({F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_LT}, -1, 4'b0010, 4'd7);
        vecs[5] = mk({F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_NO}, -1, 4'b0001, 4'd7);
        vecs[6] = mk({F_NO, F_GT, F_LT, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ}, -1, 4'b0001, 4'd0);
        vecs[7] = mk({F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_AL, F_EQ, F_EQ},  6, 4'b0001, 4'd5);
        vecs[8] = mk({F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_EQ, F_GT}, -1, 4'b1000, 4'd7);
        vecs[9] = mk({F_EQ, F_GT, F_LT, F_LT, F_LT, F_LT, F_LT, F_LT}, -1, 4'b1000, 4'd1);

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset slice_en", 32'(slice_en), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset res_valid", 32'(res_valid), 32'd0);
        chk_result("reset", 4'b0000, 4'd0);

        // Idle ignores beats
        in_valid = 1'b1;
        {in_gt, in_eq, in_lt} = F_GT;
        step();
        in_valid = 1'b0;
        chk("idle in_ready", 32'(in_ready), 32'd0);
        chk("idle busy", 32'(busy), 32'd0);

        for (int v = 0; v < 9; v++) begin
            run_word(vecs[v], 1'b0);
        end

        // Reset in SCAN at count 4 abandons the word
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            {in_gt, in_eq, in_lt} = F_EQ;
            step();
        end
        chk("pre-reset slice_en", 32'(slice_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        {in_gt, in_eq, in_lt} = F_NO;
        chk("midword reset in_ready", 32'(in_ready), 32'd0);
        chk("midword reset slice_en", 32'(slice_en), 32'd0);
        chk("midword reset busy", 32'(busy), 32'd0);
        chk("midword reset res_valid", 32'(res_valid), 32'd0);
        chk_result("midword reset", 4'b0000, 4'd0);
        step();
        chk("post reset idle busy", 32'(busy), 32'd0);
        run_word(vecs[0], 1'b0);

        // DONE held without ack, start pulsed and ignored, then start accepted
        run_word(vecs[9], 1'b1);
        run_word(vecs[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
